// File: rtl/ccd_driver_pkg.sv
// ccd_driver_pkg: shared state type, default timing constants and counter width helpers
package ccd_driver_pkg;
  typedef enum logic [1:0] {ST_LEAD, ST_ROG, ST_TRAIL, ST_READ} state_t;
  localparam int DEF_PIX_DIV   = 20;
  localparam int DEF_NPIX      = 1000;
  localparam int DEF_ROG_LEAD  = 10;
  localparam int DEF_ROG_WIDTH = 100;
  localparam int DEF_ROG_TRAIL = 10;
  localparam int DEF_CDS1_POS  = 2;
  localparam int DEF_CDS2_POS  = 12;
  localparam int DEF_CDS_W     = 3;
  localparam int DEF_PRE  = DEF_ROG_LEAD + DEF_ROG_WIDTH + DEF_ROG_TRAIL;
  localparam int DEF_LINE = DEF_PRE + DEF_NPIX * DEF_PIX_DIV;
  function automatic int cnt_w(input int n);
    return n <= 2 ? 1 : $clog2(n);
  endfunction
  function automatic int max3(input int a, input int b, input int c);
    return a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction
endpackage

// File: rtl/ccd_pixel_gen.sv
// ccd_pixel_gen: per-pixel phase counter with SH and CDS strobe decode, active only while enabled
module ccd_pixel_gen
  import ccd_driver_pkg::*;
#(
  parameter int PIX_DIV  = DEF_PIX_DIV,
  parameter int CDS1_POS = DEF_CDS1_POS,
  parameter int CDS2_POS = DEF_CDS2_POS,
  parameter int CDS_W    = DEF_CDS_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sh,
  output logic cds1,
  output logic cds2,
  output logic pix_done
);
  localparam int PW = cnt_w(PIX_DIV + 1);
  logic [PW-1:0] phase;
  always_ff @(posedge clk)
    if (!rst_n || !en) phase <= '0;
    else phase <= pix_done ? '0 : phase + 1'b1;
  always_comb begin
    pix_done = en && phase == PW'(PIX_DIV - 1);
    sh       = phase < PW'(PIX_DIV / 2);
    cds1     = phase >= PW'(CDS1_POS) && phase < PW'(CDS1_POS + CDS_W);
    cds2     = phase >= PW'(CDS2_POS) && phase < PW'(CDS2_POS + CDS_W);
  end
endmodule

// File: rtl/ccd_driver.sv
// ccd_driver: linear CCD line timing (ROG, SH) and CDS sample strobes, all outputs registered
module ccd_driver
  import ccd_driver_pkg::*;
#(
  parameter int PIX_DIV   = DEF_PIX_DIV,
  parameter int NPIX      = DEF_NPIX,
  parameter int ROG_LEAD  = DEF_ROG_LEAD,
  parameter int ROG_WIDTH = DEF_ROG_WIDTH,
  parameter int ROG_TRAIL = DEF_ROG_TRAIL,
  parameter int CDS1_POS  = DEF_CDS1_POS,
  parameter int CDS2_POS  = DEF_CDS2_POS,
  parameter int CDS_W     = DEF_CDS_W
) (
  input  logic clk,
  input  logic rst_n,
  output logic cdsclk1,
  output logic cdsclk2,
  output logic ROG,
  output logic SH
);
  localparam int CW = cnt_w(max3(ROG_LEAD, ROG_WIDTH, ROG_TRAIL));
  localparam int NW = cnt_w(NPIX);
  state_t state;
  logic [CW-1:0] cnt, cnt_last;
  logic [NW-1:0] pix;
  logic px_sh, px_c1, px_c2, pix_done, last_pix;
  always_comb begin
    cnt_last = state == ST_LEAD ? CW'(ROG_LEAD - 1) : state == ST_ROG ? CW'(ROG_WIDTH - 1) : CW'(ROG_TRAIL - 1);
    last_pix = pix == NW'(NPIX - 1);
  end
  ccd_pixel_gen #(
    .PIX_DIV(PIX_DIV), .CDS1_POS(CDS1_POS), .CDS2_POS(CDS2_POS), .CDS_W(CDS_W)
  ) u_pix (
    .clk(clk), .rst_n(rst_n), .en(state == ST_READ),
    .sh(px_sh), .cds1(px_c1), .cds2(px_c2), .pix_done(pix_done)
  );
  // outputs register the decode of the current line position before it advances
  always_ff @(posedge clk)
    if (!rst_n) begin
      state   <= ST_LEAD;
      cnt     <= '0;
      pix     <= '0;
      ROG     <= 1'b1;
      SH      <= 1'b1;
      cdsclk1 <= 1'b0;
      cdsclk2 <= 1'b0;
    end else begin
      ROG     <= state != ST_ROG;
      SH      <= state != ST_READ || px_sh;
      cdsclk1 <= state == ST_READ && px_c1;
      cdsclk2 <= state == ST_READ && px_c2;
      if (state == ST_READ) begin
        if (pix_done) begin
          pix <= last_pix ? '0 : pix + 1'b1;
          if (last_pix) state <= ST_LEAD;
        end
      end else if (cnt == cnt_last) begin
        cnt   <= '0;
        state <= state == ST_LEAD ? ST_ROG : state == ST_ROG ? ST_TRAIL : ST_READ;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: tb/tb_ccd_driver.sv
// tb_ccd_driver: directed checks of line timing against a line-index model
module tb_ccd_driver;
  localparam int LINE = 20120;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cdsclk1, cdsclk2, ROG, SH;
  int tests = 0, fails = 0, j = 0;
  ccd_driver dut (.clk(clk), .rst_n(rst_n), .cdsclk1(cdsclk1), .cdsclk2(cdsclk2), .ROG(ROG), .SH(SH));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s edge=%0d got=%0d exp=%0d", tag, j, got, exp);
    end
  endtask
  function automatic logic [3:0] model(input int l);
    int ph;
    if (l < 10) return 4'b1100;
    if (l < 110) return 4'b0100;
    if (l < 120) return 4'b1100;
    ph = (l - 120) % 20;
    return {1'b1, ph < 10, ph >= 2 && ph < 5, ph >= 12 && ph < 15};
  endfunction
  function automatic logic [3:0] outs();
    return {ROG, SH, cdsclk1, cdsclk2};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
    j++;
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check("seq", 32'(outs()), 32'(model((j - 1) % LINE)));
    end
  endtask
  task automatic pulse_reset();
    rst_n = 1'b0;
    step();
    check("mid_reset", 32'(outs()), 32'hC);
    rst_n = 1'b1;
    j = 0;
  endtask
  initial begin
    int last_fall = 0, sh_falls = 0;
    logic prev_rog = 1'b1, prev_sh = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("reset", 32'(outs()), 32'hC);
    end
    rst_n = 1'b1;
    j = 0;
    for (int i = 0; i < 3 * LINE + 20; i++) begin
      step();
      check("seq", 32'(outs()), 32'(model((j - 1) % LINE)));
      if (j == 10)  check("rog_pre", 32'(ROG), 32'd1);
      if (j == 11)  check("rog_fall", 32'(ROG), 32'd0);
      if (j == 110) check("rog_last", 32'(ROG), 32'd0);
      if (j == 111) check("rog_rise", 32'(ROG), 32'd1);
      if (j == 130) check("sh_pre", 32'(SH), 32'd1);
      if (j == 131) check("sh_fall", 32'(SH), 32'd0);
      if (j == 122) check("c1_pre", 32'(cdsclk1), 32'd0);
      if (j == 123) check("c1_on", 32'(cdsclk1), 32'd1);
      if (j == 125) check("c1_last", 32'(cdsclk1), 32'd1);
      if (j == 126) check("c1_off", 32'(cdsclk1), 32'd0);
      if (j == 133) check("c2_on", 32'(cdsclk2), 32'd1);
      if (j == 136) check("c2_off", 32'(cdsclk2), 32'd0);
      if (j == LINE + 11) check("rog_fall2", 32'(ROG), 32'd0);
      if (prev_sh && !SH) sh_falls++;
      if (prev_rog && !ROG) begin
        if (last_fall != 0) begin
          check("rog_spacing", 32'(j - last_fall), 32'(LINE));
          check("sh_falls", 32'(sh_falls), 32'd1000);
        end
        last_fall = j;
        sh_falls = 0;
      end
      prev_rog = ROG;
      prev_sh = SH;
    end
    check("third_fall", 32'(last_fall), 32'(3 * LINE + 11));
    pulse_reset();
    run(8133);
    check("pix400_c2", 32'(outs()), 32'h9);
    pulse_reset();
    run(11);
    check("restart_rog", 32'(ROG), 32'd0);
    run(39);
    check("in_rog", 32'(ROG), 32'd0);
    pulse_reset();
    run(10);
    check("restart_pre", 32'(ROG), 32'd1);
    run(1);
    check("restart_rog2", 32'(ROG), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ccd_driver.md
# ccd_driver

Timing generator for a linear CCD sensor and its CDS analog front end. It runs from one system clock and produces a repeating line sequence on four registered outputs:
- ROG: readout-gate (line transfer) pulse.
- SH: pixel shift clock to the CCD.
- cdsclk1 / cdsclk2: reset-level and video-level sample strobes to the AFE.

It sits at the sensor-facing edge of the design and has no data path.

## Interface
Parameters:
- PIX_DIV, 20: clocks per pixel (even, ≥ 8); 5 MHz pixel rate at 100 MHz.
- NPIX, 1000: pixels shifted per line, dummies included.
- ROG_LEAD, 10: clocks SH is held high before ROG asserts.
- ROG_WIDTH, 100: ROG low width in clocks.
- ROG_TRAIL, 10: clocks SH is held high after ROG deasserts.
- CDS1_POS, 2: pixel phase where cdsclk1 rises.
- CDS2_POS, 12: pixel phase where cdsclk2 rises.
- CDS_W, 3: width of each CDS strobe in clocks.

Ports:
- clk  in  1: system clock, 100 MHz nominal.
- rst_n  in  1: reset. One clock; reset is synchronous and active-low.
- cdsclk1  out  1: reset-level sample strobe, active high.
- cdsclk2  out  1: video-level sample strobe, active high.
- ROG  out  1: readout gate, active low.
- SH  out  1: CCD shift clock.

## Operation
- Line period: LINE = ROG_LEAD + ROG_WIDTH + ROG_TRAIL + NPIX·PIX_DIV clocks (20120 with defaults).
- A line index L runs from 0 to LINE−1 and then wraps to 0. The sequence free-runs with no idle gaps.
- PRE = ROG_LEAD + ROG_WIDTH + ROG_TRAIL (120 with defaults).
- State machine, decoded from L:
  - LEAD, L in [0, ROG_LEAD): SH=1, ROG=1, cdsclk1=0, cdsclk2=0.
  - ROG, L in [ROG_LEAD, ROG_LEAD+ROG_WIDTH): ROG=0, SH=1, CDS strobes 0.
  - TRAIL, next ROG_TRAIL clocks: ROG=1, SH=1, CDS strobes 0.
  - READ, L in [PRE, LINE):
    - Pixel index p = (L−PRE) div PIX_DIV.
    - Phase φ = (L−PRE) mod PIX_DIV.
- Outputs in READ:
  - SH = 1 for φ < PIX_DIV/2, otherwise 0.
  - cdsclk1 = 1 for φ in [CDS1_POS, CDS1_POS+CDS_W).
  - cdsclk2 = 1 for φ in [CDS2_POS, CDS2_POS+CDS_W).
  - ROG = 1.
- Legal parameters require:
  - CDS1_POS+CDS_W ≤ PIX_DIV/2, so the reset sample falls in SH high.
  - CDS2_POS ≥ PIX_DIV/2 and CDS2_POS+CDS_W ≤ PIX_DIV, so the video sample falls in SH low.
  - cdsclk1 and cdsclk2 are never high together.
- Implementation: separate phase and pixel counters, no dividers. Transitions LEAD→ROG→TRAIL→READ→LEAD.

## Timing
- Reset values, on any rising edge with rst_n=0:
  - L = 0, state LEAD.
  - ROG=1, SH=1, cdsclk1=0, cdsclk2=0.
- Every output comes from a register, giving glitch-free edges.
- On each rising edge with rst_n=1:
  - The output registers load the decode of the current L.
  - L then advances.
  - So after the j-th edge since release, outputs reflect L = (j−1) mod LINE.
- With defaults, counting edges after release:
  - ROG falls at edge 11 and rises at edge 111.
  - The first SH falling edge is at edge 131.
  - cdsclk1 is high on edges 123–125.
  - cdsclk2 is high on edges 133–135.
- Wrap: the clock after L=LINE−1 is L=0 (LEAD). The next ROG falls exactly LINE clocks after the previous one.
- Reset mid-line: sampled synchronously. Outputs return to reset values on that edge, even if a ROG pulse is in progress. The sequence restarts from L=0 on release.
- No asynchronous paths. rst_n has no effect between edges.

## Structure
- Package ccd_driver_pkg holds:
  - The state enum (LEAD, ROG, TRAIL, READ).
  - Default timing constants.
  - Derived constants PRE and LINE.
  - Counter width functions ($clog2 of PIX_DIV, NPIX and the max phase count).
- Natural sub-module: ccd_pixel_gen.
  - Contents: the phase counter plus the SH/cdsclk1/cdsclk2 decode.
  - Enabled only in READ.
  - Emits a pixel-done pulse consumed by the top-level line FSM.
- Top level ccd_driver holds the state FSM, the LEAD/ROG/TRAIL counter, the pixel counter and the output registers.

## Test plan
- Reset: hold rst_n=0 for 10 clocks → ROG=1, SH=1, cdsclk1=0, cdsclk2=0 on every edge.
- ROG pulse: release reset → ROG low exactly for edges 11–110 (100 clocks), SH=1 throughout edges 1–130.
- Pixel clocking: in READ, SH has period 20 clocks and 50% duty. Exactly 1000 SH falling edges occur between consecutive ROG pulses.
- CDS placement: in every pixel, cdsclk1 is high for 3 clocks inside SH high and cdsclk2 is high for 3 clocks inside SH low. The two strobes never overlap.
- Wrap: the ROG falling-edge spacing over three lines is 20120 clocks each.
- Mid-line reset: assert rst_n=0 for one edge during pixel 400 and during the ROG pulse → outputs go to reset values on that edge. ROG next falls 11 edges after release.
